// File: rtl/huf_pkg.sv
// Shared Huffman constants and types for the code builder, decoder and encoder.
package huf_pkg;

    localparam int CODE_W = 6;
    localparam int SYM_N  = 10;

    // Sentinel format: the leading 1 marks the length, so a lone 1 is an empty code.
    localparam logic [CODE_W-1:0] CODE_NONE = CODE_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        EMIT  = 2'b10,
        ERR   = 2'b11
    } state_t;

    typedef logic [SYM_N-1:0][CODE_W-1:0] code_tbl_t;

endpackage

// File: rtl/huf_match.sv
// Combinational codeword matcher: compares a candidate against the table, lowest index wins.
module huf_match
    import huf_pkg::*;
(
    input  logic [CODE_W-1:0] nxt,
    input  code_tbl_t         tbl,
    output logic              hit,
    output logic [3:0]        idx,
    output logic              over
);

    assign over = nxt[CODE_W-1];

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = SYM_N - 1; i >= 0; i--) begin
            if (tbl[i] != CODE_NONE && tbl[i] == nxt) begin
                hit = 1'b1;
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/huf_decoder.sv
// Serial Huffman decoder: shifts in code bits MSB first and emits one digit per matched codeword.
module huf_decoder
    import huf_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Tbl_vld,
    input  logic [CODE_W-1:0] Code0,
    input  logic [CODE_W-1:0] Code1,
    input  logic [CODE_W-1:0] Code2,
    input  logic [CODE_W-1:0] Code3,
    input  logic [CODE_W-1:0] Code4,
    input  logic [CODE_W-1:0] Code5,
    input  logic [CODE_W-1:0] Code6,
    input  logic [CODE_W-1:0] Code7,
    input  logic [CODE_W-1:0] Code8,
    input  logic [CODE_W-1:0] Code9,
    input  logic              Bit_in,
    input  logic              Bit_vld,
    output logic              Bit_rdy,
    output logic [3:0]        Sym,
    output logic              Sym_vld,
    input  logic              Sym_rdy,
    output logic              Err,
    input  logic              Err_clr,
    output logic [CNT_W-1:0]  Sym_cnt
);

    // The accumulator never holds a set top bit (that case is an error), so it drops it.
    localparam logic [CODE_W-2:0] ACC_EMPTY = (CODE_W-1)'(1);

    state_t            state_q, state_d;
    code_tbl_t         tbl_q;
    code_tbl_t         code_in;
    logic              tbl_ld;
    logic [CODE_W-2:0] acc_q, acc_d;
    logic [3:0]        sym_q, sym_d;
    logic              sym_vld_q, sym_vld_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] nxt;
    logic              hit, over;
    logic [3:0]        idx;

    assign code_in = {Code9, Code8, Code7, Code6, Code5, Code4, Code3, Code2, Code1, Code0};
    assign nxt     = {acc_q, Bit_in};

    huf_match u_match (
        .nxt  (nxt),
        .tbl  (tbl_q),
        .hit  (hit),
        .idx  (idx),
        .over (over)
    );

    // A dropped table blocks bit acceptance in the same cycle it forces IDLE.
    assign Bit_rdy = (state_q == SHIFT) && Tbl_vld;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sym_d     = sym_q;
        sym_vld_d = sym_vld_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        tbl_ld    = 1'b0;

        if (state_q != IDLE && !Tbl_vld) begin
            state_d   = IDLE;
            sym_vld_d = 1'b0;
            acc_d     = ACC_EMPTY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Err_clr) err_d = 1'b0;
                    if (Tbl_vld) begin
                        tbl_ld  = 1'b1;
                        acc_d   = ACC_EMPTY;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (Bit_vld) begin
                        if (hit) begin
                            sym_d     = idx;
                            sym_vld_d = 1'b1;
                            acc_d     = ACC_EMPTY;
                            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                            state_d   = EMIT;
                        end else if (over) begin
                            err_d   = 1'b1;
                            acc_d   = ACC_EMPTY;
                            state_d = ERR;
                        end else begin
                            acc_d = nxt[CODE_W-2:0];
                        end
                    end
                end
                EMIT: begin
                    if (Sym_rdy) begin
                        sym_vld_d = 1'b0;
                        state_d   = SHIFT;
                    end
                end
                ERR: begin
                    if (Err_clr) begin
                        err_d   = 1'b0;
                        acc_d   = ACC_EMPTY;
                        state_d = SHIFT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the table is only ten small registers, so it is reset rather than left as an unreset memory.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            tbl_q     <= {SYM_N{CODE_NONE}};
            acc_q     <= ACC_EMPTY;
            sym_q     <= '0;
            sym_vld_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sym_q     <= sym_d;
            sym_vld_q <= sym_vld_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            if (tbl_ld) tbl_q <= code_in;
        end
    end

    assign Sym     = sym_q;
    assign Sym_vld = sym_vld_q;
    assign Err     = err_q;
    assign Sym_cnt = cnt_q;

endmodule

// File: tb/tb_huf_decoder.sv
// Directed bench for huf_decoder: table-driven cycle vectors plus hand-written corner sequences.
module tb_huf_decoder;
    import huf_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Tbl_vld;
    logic [CODE_W-1:0] code [SYM_N];
    logic              Bit_in, Bit_vld, Bit_rdy;
    logic [3:0]        Sym;
    logic              Sym_vld, Sym_rdy;
    logic              Err, Err_clr;
    logic [7:0]        Sym_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       bit_v;
        logic       b;
        logic       rdy;
        logic       exp_vld;
        logic [3:0] exp_sym;
        logic       exp_brdy;
    } vec_t;

    vec_t vecs [17];

    always #5 Clk = ~Clk;

    huf_decoder #(.CNT_W(8)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Tbl_vld (Tbl_vld),
        .Code0   (code[0]),
        .Code1   (code[1]),
        .Code2   (code[2]),
        .Code3   (code[3]),
        .Code4   (code[4]),
        .Code5   (code[5]),
        .Code6   (code[6]),
        .Code7   (code[7]),
        .Code8   (code[8]),
        .Code9   (code[9]),
        .Bit_in  (Bit_in),
        .Bit_vld (Bit_vld),
        .Bit_rdy (Bit_rdy),
        .Sym     (Sym),
        .Sym_vld (Sym_vld),
        .Sym_rdy (Sym_rdy),
        .Err     (Err),
        .Err_clr (Err_clr),
        .Sym_cnt (Sym_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives inputs at a falling edge, crosses one rising edge, returns at the next falling edge.
    task automatic step(input logic vld, input logic b, input logic rdy);
        Bit_vld = vld;
        Bit_in  = b;
        Sym_rdy = rdy;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clear_codes();
        for (int i = 0; i < SYM_N; i++) code[i] = CODE_NONE;
    endtask

    task automatic basic_codes();
        clear_codes();
        code[0] = 6'b000010;
        code[1] = 6'b000110;
        code[2] = 6'b000111;
    endtask

    task automatic load_table();
        Tbl_vld = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        Tbl_vld = 1'b1;
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        vecs = '{
            '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1},
            '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1},
            '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1}
        };

        Reset   = 1'b0;
        Tbl_vld = 1'b0;
        Err_clr = 1'b0;
        Bit_in  = 1'b0;
        Bit_vld = 1'b0;
        Sym_rdy = 1'b1;
        basic_codes();
        repeat (2) @(negedge Clk);
        check("rst_bit_rdy", 32'(Bit_rdy), 0);
        check("rst_sym", 32'(Sym), 0);
        check("rst_sym_vld", 32'(Sym_vld), 0);
        check("rst_err", 32'(Err), 0);
        check("rst_cnt", 32'(Sym_cnt), 0);
        Reset = 1'b1;

        // Basic decode followed by backpressure, one vector per clock.
        load_table();
        check("load_bit_rdy", 32'(Bit_rdy), 1);
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].bit_v, vecs[i].b, vecs[i].rdy);
            check($sformatf("vec%0d_sym_vld", i), 32'(Sym_vld), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) check($sformatf("vec%0d_sym", i), 32'(Sym), 32'(vecs[i].exp_sym));
            check($sformatf("vec%0d_bit_rdy", i), 32'(Bit_rdy), 32'(vecs[i].exp_brdy));
            if (i == 7) begin
                check("basic_cnt", 32'(Sym_cnt), 3);
                check("basic_err", 32'(Err), 0);
            end
        end
        check("bp_cnt", 32'(Sym_cnt), 5);

        // Error after five unmatched bits, then recovery.
        clear_codes();
        code[3] = 6'b100000;
        load_table();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check($sformatf("err_bit%0d_vld", i), 32'(Sym_vld), 0);
            if (i < 4) check($sformatf("err_bit%0d_err", i), 32'(Err), 0);
        end
        check("err_set", 32'(Err), 1);
        check("err_bit_rdy", 32'(Bit_rdy), 0);
        step(1'b1, 1'b0, 1'b1);
        check("err_sticky", 32'(Err), 1);
        Err_clr = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        Err_clr = 1'b0;
        check("err_clr", 32'(Err), 0);
        check("err_clr_bit_rdy", 32'(Bit_rdy), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        check("err_rec_vld", 32'(Sym_vld), 1);
        check("err_rec_sym", 32'(Sym), 3);
        check("err_rec_cnt", 32'(Sym_cnt), 1);
        step(1'b0, 1'b0, 1'b1);

        // Table reload drops a half-received codeword.
        basic_codes();
        load_table();
        step(1'b1, 1'b0, 1'b1);
        check("rl_first_sym", 32'(Sym), 0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("rl_partial_vld", 32'(Sym_vld), 0);
        Tbl_vld = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        check("rl_idle_bit_rdy", 32'(Bit_rdy), 0);
        Tbl_vld = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        check("rl_cnt_zero", 32'(Sym_cnt), 0);
        step(1'b1, 1'b0, 1'b1);
        check("rl_vld", 32'(Sym_vld), 1);
        check("rl_sym", 32'(Sym), 0);
        step(1'b0, 1'b0, 1'b1);

        // Counter saturation with a continuous stream of "0".
        load_table();
        Bit_vld = 1'b1;
        Bit_in  = 1'b0;
        Sym_rdy = 1'b1;
        n = 0;
        for (int c = 0; c < 1000 && n < 300; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Sym_vld) begin
                n++;
                if (n == 200) check("cnt_200", 32'(Sym_cnt), 200);
            end
        end
        Bit_vld = 1'b0;
        check("sat_symbols", 32'(n), 300);
        step(1'b0, 1'b0, 1'b1);
        check("cnt_sat", 32'(Sym_cnt), 255);

        // Asynchronous reset while a symbol is pending.
        step(1'b1, 1'b0, 1'b0);
        check("rstm_vld_before", 32'(Sym_vld), 1);
        Reset = 1'b0;
        #1;
        check("rstm_vld", 32'(Sym_vld), 0);
        check("rstm_cnt", 32'(Sym_cnt), 0);
        check("rstm_state", 32'(dut.state_q), 32'(IDLE));
        check("rstm_bit_rdy", 32'(Bit_rdy), 0);

        // Duplicate codewords: lowest index wins; table input changes after the latch are ignored.
        clear_codes();
        code[4] = 6'b000101;
        code[7] = 6'b000101;
        @(negedge Clk);
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        code[4] = CODE_NONE;
        step(1'b1, 1'b0, 1'b1);
        check("dup_first_vld", 32'(Sym_vld), 0);
        step(1'b1, 1'b1, 1'b1);
        check("dup_vld", 32'(Sym_vld), 1);
        check("dup_sym", 32'(Sym), 4);
        step(1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
